// File: rtl/sprite_pkg.sv
// ============================================================================
// Module      : sprite_pkg
// Description : Shared colour constants, default colour width and the
//               grid-cell clamp/wrap contract for the sprite cell engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_pkg;

    localparam int c_COLOR_W = 3;

    localparam logic [c_COLOR_W-1:0] c_BLACK   = 3'b000;
    localparam logic [c_COLOR_W-1:0] c_BLUE    = 3'b001;
    localparam logic [c_COLOR_W-1:0] c_GREEN   = 3'b010;
    localparam logic [c_COLOR_W-1:0] c_CYAN    = 3'b011;
    localparam logic [c_COLOR_W-1:0] c_RED     = 3'b100;
    localparam logic [c_COLOR_W-1:0] c_MAGENTA = 3'b101;
    localparam logic [c_COLOR_W-1:0] c_YELLOW  = 3'b110;
    localparam logic [c_COLOR_W-1:0] c_WHITE   = 3'b111;

    // Absolute loads saturate to the last cell. Relative moves instead wrap:
    // result = (base + delta) mod limit, always in 0..limit-1 (see grid_wrap_add).
    function automatic int unsigned clampToGrid(input int unsigned value,
                                                input int unsigned limit);
        return (value < limit) ? value : limit - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/grid_wrap_add.sv
// ============================================================================
// Module      : grid_wrap_add
// Description : Signed cell step with true non-negative modulo LIMIT wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_wrap_add #(
    parameter int GRID_BITS = 6,
    parameter int LIMIT     = 40
) (
    input  logic [GRID_BITS-1:0] iBase,
    input  logic [GRID_BITS-1:0] iDelta,
    output logic [GRID_BITS-1:0] oSum
);

    localparam int c_SW = GRID_BITS + 3;
    localparam logic signed [c_SW-1:0] c_LIMIT = c_SW'(LIMIT);

    logic signed [c_SW-1:0] w_sum0;
    logic signed [c_SW-1:0] w_sum1;
    logic signed [c_SW-1:0] w_sum2;
    logic [2:0]             w_unusedHi;

    // With base < LIMIT and LIMIT >= 2^(GRID_BITS-2), the raw sum lies in
    // (-2*LIMIT, 3*LIMIT), so two correction stages always suffice.
    assign w_sum0 = $signed({3'b000, iBase}) + c_SW'($signed(iDelta));

    assign w_sum1 = w_sum0[c_SW-1]      ? w_sum0 + c_LIMIT :
                    (w_sum0 >= c_LIMIT) ? w_sum0 - c_LIMIT : w_sum0;

    assign w_sum2 = w_sum1[c_SW-1]      ? w_sum1 + c_LIMIT :
                    (w_sum1 >= c_LIMIT) ? w_sum1 - c_LIMIT : w_sum1;

    assign {w_unusedHi, oSum} = w_sum2;

endmodule

`default_nettype wire

// File: rtl/sprite_cell_engine.sv
// ============================================================================
// Module      : sprite_cell_engine
// Description : SIZE x SIZE grid-cell sprite overlay with registered pixel
//               output. Optional per-frame auto-motion: SPRITE_AUTOMOVE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_cell_engine
    import sprite_pkg::*;
#(
    parameter int                   SIZE      = 16,
    parameter int                   GRID_BITS = 6,
    parameter int                   GRID_W    = 40,
    parameter int                   GRID_H    = 30,
    parameter int                   COLOR_W   = c_COLOR_W,
    parameter logic [COLOR_W-1:0]   COLOR_RST = COLOR_W'(c_BLUE),
    parameter int                   VEL_BITS  = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [9:0]           iColumnCount,
    input  logic [9:0]           iRowCount,
    input  logic                 iEnable,
    input  logic [COLOR_W-1:0]   iColorBack,
    input  logic                 iChangePos,
    input  logic                 iAbsolute,
    input  logic [GRID_BITS-1:0] iSetX,
    input  logic [GRID_BITS-1:0] iSetY,
    input  logic [COLOR_W-1:0]   iNewColor,
    input  logic                 iSetColor,
    input  logic                 iFrameTick,
    input  logic                 iSetVel,
    input  logic [VEL_BITS-1:0]  iVelX,
    input  logic [VEL_BITS-1:0]  iVelY,
    output logic [COLOR_W-1:0]   oRGB,
    output logic                 oHit
);

    localparam int c_SIZE_LOG = $clog2(SIZE);
    localparam int c_PW_RAW   = GRID_BITS + c_SIZE_LOG + 1;
    localparam int c_PW       = (c_PW_RAW > 11) ? c_PW_RAW : 11;

    logic [GRID_BITS-1:0] r_posX;
    logic [GRID_BITS-1:0] r_posY;
    logic [COLOR_W-1:0]   r_color;

    logic [GRID_BITS-1:0] w_deltaX;
    logic [GRID_BITS-1:0] w_deltaY;
    logic [GRID_BITS-1:0] w_wrapX;
    logic [GRID_BITS-1:0] w_wrapY;
    logic [GRID_BITS-1:0] w_absX;
    logic [GRID_BITS-1:0] w_absY;
    logic                 w_autoStep;

`ifdef SPRITE_AUTOMOVE_EN
    logic [VEL_BITS-1:0] r_velX;
    logic [VEL_BITS-1:0] r_velY;

    // One adder per axis serves both relative commands and frame motion.
    assign w_deltaX   = iChangePos ? iSetX : GRID_BITS'($signed(r_velX));
    assign w_deltaY   = iChangePos ? iSetY : GRID_BITS'($signed(r_velY));
    assign w_autoStep = iFrameTick;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_velX <= '0;
            r_velY <= '0;
        end else if (iSetVel) begin
            r_velX <= iVelX;
            r_velY <= iVelY;
        end
    end
`else
    logic w_unusedMotion;

    assign w_deltaX       = iSetX;
    assign w_deltaY       = iSetY;
    assign w_autoStep     = 1'b0;
    assign w_unusedMotion = ^{iFrameTick, iSetVel, iVelX, iVelY};
`endif

    grid_wrap_add #(
        .GRID_BITS (GRID_BITS),
        .LIMIT     (GRID_W)
    ) u_wrapX (
        .iBase  (r_posX),
        .iDelta (w_deltaX),
        .oSum   (w_wrapX)
    );

    grid_wrap_add #(
        .GRID_BITS (GRID_BITS),
        .LIMIT     (GRID_H)
    ) u_wrapY (
        .iBase  (r_posY),
        .iDelta (w_deltaY),
        .oSum   (w_wrapY)
    );

    assign w_absX = GRID_BITS'(clampToGrid(32'(iSetX), GRID_W));
    assign w_absY = GRID_BITS'(clampToGrid(32'(iSetY), GRID_H));

    // Pixel bounds are widened so off-screen cells never alias onto the screen.
    logic [c_PW-1:0] w_colStart;
    logic [c_PW-1:0] w_rowStart;
    logic [c_PW-1:0] w_col;
    logic [c_PW-1:0] w_row;
    logic            w_hit;

    assign w_colStart = c_PW'(r_posX) << c_SIZE_LOG;
    assign w_rowStart = c_PW'(r_posY) << c_SIZE_LOG;
    assign w_col      = c_PW'(iColumnCount);
    assign w_row      = c_PW'(iRowCount);

    assign w_hit = (w_col >= w_colStart) && (w_col < w_colStart + c_PW'(SIZE)) &&
                   (w_row >= w_rowStart) && (w_row < w_rowStart + c_PW'(SIZE));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_posX  <= '0;
            r_posY  <= '0;
            r_color <= COLOR_RST;
            oRGB    <= '0;
            oHit    <= 1'b0;
        end else begin
            if (iChangePos) begin
                r_posX <= iAbsolute ? w_absX : w_wrapX;
                r_posY <= iAbsolute ? w_absY : w_wrapY;
            end else if (w_autoStep) begin
                r_posX <= w_wrapX;
                r_posY <= w_wrapY;
            end
            if (iSetColor) begin
                r_color <= iNewColor;
            end
            oHit <= iEnable && w_hit;
            oRGB <= (iEnable && w_hit) ? r_color : iColorBack;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_cell_engine.sv
// ============================================================================
// Module      : tb_sprite_cell_engine
// Description : Directed self-checking bench for sprite_cell_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_cell_engine;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [9:0] iColumnCount, iRowCount;
    logic       iEnable;
    logic [2:0] iColorBack;
    logic       iChangePos, iAbsolute;
    logic [5:0] iSetX, iSetY;
    logic [2:0] iNewColor;
    logic       iSetColor, iFrameTick, iSetVel;
    logic [2:0] iVelX, iVelY;
    logic [2:0] oRGB;
    logic       oHit;

    int tests = 0;
    int fails = 0;

    sprite_cell_engine dut (
        .Clock(Clock), .Reset(Reset),
        .iColumnCount(iColumnCount), .iRowCount(iRowCount),
        .iEnable(iEnable), .iColorBack(iColorBack),
        .iChangePos(iChangePos), .iAbsolute(iAbsolute),
        .iSetX(iSetX), .iSetY(iSetY),
        .iNewColor(iNewColor), .iSetColor(iSetColor),
        .iFrameTick(iFrameTick), .iSetVel(iSetVel),
        .iVelX(iVelX), .iVelY(iVelY),
        .oRGB(oRGB), .oHit(oHit)
    );

    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present one pixel for one edge, then check the registered result.
    task automatic px(input string tag, input int col, input int row,
                      input logic expHit, input logic [2:0] expRgb);
        iColumnCount = 10'(col);
        iRowCount    = 10'(row);
        step();
        chk({tag, "_hit"}, 32'(oHit), 32'(expHit));
        chk({tag, "_rgb"}, 32'(oRGB), 32'(expRgb));
    endtask

    task automatic setPos(input logic absMode, input logic [5:0] x, input logic [5:0] y,
                          input int cycles);
        iChangePos = 1'b1;
        iAbsolute  = absMode;
        iSetX      = x;
        iSetY      = y;
        repeat (cycles) step();
        iChangePos = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; iColumnCount = '0; iRowCount = '0; iEnable = 1'b0;
        iColorBack = 3'b111; iChangePos = 1'b0; iAbsolute = 1'b0;
        iSetX = '0; iSetY = '0; iNewColor = '0; iSetColor = 1'b0;
        iFrameTick = 1'b0; iSetVel = 1'b0; iVelX = '0; iVelY = '0;
        step();
        step();
        chk("reset_rgb", 32'(oRGB), 32'h0);
        chk("reset_hit", 32'(oHit), 32'h0);
        Reset = 1'b0;
        iEnable = 1'b1;

        px("default_in", 5, 5, 1'b1, 3'b001);
        px("default_col16", 16, 5, 1'b0, 3'b111);
        px("default_15_15", 15, 15, 1'b1, 3'b001);

        setPos(1'b1, 6'd2, 6'd3, 1);
        px("abs_32_48", 32, 48, 1'b1, 3'b001);
        px("abs_31_48", 31, 48, 1'b0, 3'b111);
        px("abs_47_63", 47, 63, 1'b1, 3'b001);
        px("abs_48_63", 48, 63, 1'b0, 3'b111);
        px("abs_32_47", 32, 47, 1'b0, 3'b111);

        setPos(1'b1, 6'd63, 6'd63, 1);
        px("clamp_624_464", 624, 464, 1'b1, 3'b001);
        px("clamp_623_464", 623, 464, 1'b0, 3'b111);
        px("clamp_639_479", 639, 479, 1'b1, 3'b001);

        setPos(1'b1, 6'd0, 6'd0, 1);
        setPos(1'b0, 6'h3F, 6'h3E, 1);
        px("relneg_624_448", 624, 448, 1'b1, 3'b001);
        px("relneg_624_447", 624, 447, 1'b0, 3'b111);

        setPos(1'b1, 6'd38, 6'd0, 1);
        setPos(1'b0, 6'd1, 6'd0, 3);
        px("relheld_16_0", 16, 0, 1'b1, 3'b001);
        px("relheld_15_0", 15, 0, 1'b0, 3'b111);

        // Colour and position load together; output lags the update by one edge.
        iSetColor = 1'b1; iNewColor = 3'b100;
        iColumnCount = 10'd32; iRowCount = 10'd32;
        setPos(1'b1, 6'd2, 6'd2, 1);
        iSetColor = 1'b0;
        chk("latency_hit", 32'(oHit), 32'h0);
        chk("latency_rgb", 32'(oRGB), 32'h7);
        px("color_32_32", 32, 32, 1'b1, 3'b100);
        iEnable = 1'b0; iColorBack = 3'b010;
        px("disabled_32_32", 32, 32, 1'b0, 3'b010);
        iEnable = 1'b1; iColorBack = 3'b111;

`ifdef SPRITE_AUTOMOVE_EN
        setPos(1'b1, 6'd38, 6'd0, 1);
        iSetVel = 1'b1; iVelX = 3'sd3; iVelY = 3'b111;
        step();
        iSetVel = 1'b0;
        iFrameTick = 1'b1; step(); iFrameTick = 1'b0; step();
        iFrameTick = 1'b1; step(); iFrameTick = 1'b0;
        px("auto_64_448", 64, 448, 1'b1, 3'b100);
        px("auto_63_448", 63, 448, 1'b0, 3'b111);
        iFrameTick = 1'b1;
        setPos(1'b1, 6'd5, 6'd5, 1);
        iFrameTick = 1'b0;
        px("tickdrop_80_80", 80, 80, 1'b1, 3'b100);
        px("tickdrop_128_64", 128, 64, 1'b0, 3'b111);
`else
        setPos(1'b1, 6'd5, 6'd5, 1);
        iSetVel = 1'b1; iVelX = 3'sd3; iVelY = 3'sd1;
        step();
        iSetVel = 1'b0;
        iFrameTick = 1'b1; step(); iFrameTick = 1'b0;
        px("noauto_80_80", 80, 80, 1'b1, 3'b100);
        px("noauto_128_96", 128, 96, 1'b0, 3'b111);
`endif

        setPos(1'b1, 6'd10, 6'd10, 1);
        iColumnCount = 10'd0; iRowCount = 10'd0;
        iChangePos = 1'b1; iAbsolute = 1'b0; iSetX = 6'd1; iSetY = 6'd1;
        step();
        Reset = 1'b1;
        step();
        chk("rst_held_rgb", 32'(oRGB), 32'h0);
        chk("rst_held_hit", 32'(oHit), 32'h0);
        Reset = 1'b0;
        step();
        iChangePos = 1'b0;
        px("resume_16_16", 16, 16, 1'b1, 3'b001);
        px("resume_15_16", 15, 16, 1'b0, 3'b111);
        px("resume_32_32", 32, 32, 1'b0, 3'b111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
